threshold_monitor: RTL
======================

Name: threshold_monitor

Overview:
- Downstream consumer of the 8-bit magnitude-compare stage.
- Accepts a stream of 8-bit samples under valid/ready and compares each against programmable high/low thresholds.
- Debounces the crossings through a hysteresis state machine and raises an alarm.
- Reports each alarm transition as an event under a valid/ready handshake to the control/display logic.

Parameters:
- DEBOUNCE, 3: consecutive qualifying samples required to enter or leave alarm; legal range 1..15.
- CNT_W, 4: width of the debounce counter; must hold DEBOUNCE.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  block can accept a sample this cycle
- sample_in  input  8  unsigned sample
- threshold_hi  input  8  unsigned alarm-set level; sampled on each accepted sample
- threshold_lo  input  8  unsigned alarm-clear level; must be <= threshold_hi
- alarm  output  1  debounced alarm state
- event_valid  output  1  an alarm transition is pending
- event_ready  input  1  consumer accepts the event
- event_rise  output  1  1 = alarm set, 0 = alarm cleared; valid while event_valid
- peak_max  output  8  largest sample since reset (optional feature)
- peak_min  output  8  smallest sample since reset (optional feature)

Behaviour:
- Reset clears all state asynchronously. Outputs on reset:
  - alarm = 0, event_valid = 0, event_rise = 0, sample_ready = 1
  - peak_max = 8'h00, peak_min = 8'hFF
  - state = NORMAL, debounce counter = 0
- Accept rule: a sample is accepted when sample_valid && sample_ready at a rising edge.
- Compare rules, unsigned, 8-bit, no width extension:
  - above = sample_in > threshold_hi
  - below = sample_in < threshold_lo
  - Equality with either threshold is neither above nor below.
- Counter saturates at DEBOUNCE. The FSM acts only on accepted samples:
  - NORMAL: above -> PEND_SET, cnt = 1. Otherwise stay, cnt = 0.
  - PEND_SET: if above, cnt++; when cnt reaches DEBOUNCE -> ALARM. If not above -> NORMAL, cnt = 0.
  - ALARM: below -> PEND_CLR, cnt = 1. Otherwise stay, cnt = 0.
  - PEND_CLR: if below, cnt++; when cnt reaches DEBOUNCE -> NORMAL. If not below -> ALARM, cnt = 0.
  - With DEBOUNCE = 1, NORMAL goes straight to ALARM (and ALARM straight to NORMAL) on the first qualifying sample; PEND states are skipped.
- Latency: alarm and event outputs update on the same edge that accepts the deciding sample; visible 1 cycle after the handshake.
- Event on entering ALARM: event_valid = 1, event_rise = 1, alarm = 1.
- Event on entering NORMAL from PEND_CLR: event_valid = 1, event_rise = 0, alarm = 0.
- event_valid holds, with event_rise stable, until event_valid && event_ready at an edge, then clears.
- sample_ready = !event_valid. There is a single event slot, so a second transition can never overwrite an unacknowledged one.
- Simultaneous sample_valid and event_ready while event_valid: the event is consumed. The sample is not accepted that cycle and is accepted the next cycle.
- Thresholds are not registered; changing them mid-debounce affects only subsequent samples. The counter is not reset.
- Reset asserted mid-debounce or with an event pending discards all state; no event is emitted.

Optional Feature:
- Macro: THRESHOLD_MONITOR_PEAK_EN.
- Defined: on each accepted sample:
  - peak_max <= max(peak_max, sample_in)
  - peak_min <= min(peak_min, sample_in)
  - Ties leave the value unchanged; updates occur regardless of FSM state.
- Undefined: no peak registers are built; peak_max is tied to 8'h00 and peak_min to 8'hFF. The port list is identical in both builds.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_NORMAL = 2'd0, ST_PEND_SET = 2'd1, ST_ALARM = 2'd2, ST_PEND_CLR = 2'd3
  - default DEBOUNCE value
  - SAMPLE_W = 8
- One natural sub-module: debounce_counter. It is a saturating CNT_W counter with inputs inc and clr and output reached (cnt == DEBOUNCE).
- Threshold compares use the team's existing 8-bit comparator instances: two of them, for hi and lo.

Test Plan:
- Reset check: pulse rst for 2 cycles -> alarm = 0, event_valid = 0, sample_ready = 1, peak_max = 00, peak_min = FF.
- Set path: hi = 100, lo = 50, DEBOUNCE = 3; samples 101, 120, 200 with event_ready = 0 -> after the third accept, alarm = 1, event_valid = 1, event_rise = 1, sample_ready = 0.
- Interrupted debounce and equality: hi = 100; samples 150, 150, 100, 150, 150 -> no alarm, because 100 equals the threshold and resets the count. A further 150 -> alarm = 1.
- Clear path with backpressure: from ALARM with lo = 50, samples 10, 49, 30 -> event_rise = 0, alarm = 0. Hold event_ready = 0 for 5 cycles with sample_valid = 1 -> no sample accepted. Raise event_ready -> event consumed; the held sample is accepted the next cycle.
- Reset mid-operation: assert rst while in PEND_SET with cnt = 2 -> state returns to NORMAL. Two further 150 samples give no alarm; a third gives the alarm.
- PEAK_EN build: samples 7, 200, 3, 200 -> peak_max = 200, peak_min = 3. Non-PEAK_EN build -> peak_max = 00, peak_min = FF throughout.

Source files
------------

// File: rtl/threshold_monitor_pkg.sv
// Shared definitions for the threshold monitor: sample width, debounce
// defaults and the hysteresis FSM state encoding.
package threshold_monitor_pkg;

    localparam int unsigned SAMPLE_W         = 8;
    localparam int unsigned DEBOUNCE_DEFAULT = 3;
    localparam int unsigned CNT_W_DEFAULT    = 4;

    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_PEND_SET = 2'd1;
    localparam logic [1:0] ST_ALARM    = 2'd2;
    localparam logic [1:0] ST_PEND_CLR = 2'd3;

endpackage

// File: rtl/threshold_monitor_cmp8.sv
// Unsigned 8-bit magnitude compare: flags a strictly greater than b.
module threshold_monitor_cmp8
    import threshold_monitor_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic                aGtB_c
);

    // Strict compare; equality is reported as not greater.
    assign aGtB_c = (a > b);

endmodule

// File: rtl/threshold_monitor_debounce_counter.sv
// Saturating debounce counter. reached_c flags that the count including the
// current increment equals DEBOUNCE, so the FSM can decide on the same edge
// that accepts the deciding sample. clr has priority over inc.
module threshold_monitor_debounce_counter
    import threshold_monitor_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic reached_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntInc;

    // Saturating increment value
    always_comb begin
        cntInc = cnt;
        if (cnt != CNT_W'(DEBOUNCE)) begin
            cntInc = cnt + CNT_W'(1);
        end
    end

    assign reached_c = inc && (cntInc == CNT_W'(DEBOUNCE));

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cntInc;
        end
    end

endmodule

// File: rtl/threshold_monitor.sv
// Threshold monitor: compares accepted samples against hi/lo thresholds,
// debounces crossings through a hysteresis FSM and reports each alarm
// transition through a single-slot valid/ready event.
// Optional build macro: THRESHOLD_MONITOR_PEAK_EN (peak max/min tracking).
module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [SAMPLE_W-1:0] threshold_hi,
    input  logic [SAMPLE_W-1:0] threshold_lo,
    output logic                alarm,
    output logic                event_valid,
    input  logic                event_ready,
    output logic                event_rise,
    output logic [SAMPLE_W-1:0] peak_max,
    output logic [SAMPLE_W-1:0] peak_min
);

    logic [1:0] state;
    logic [1:0] stateNext;
    logic       accept;
    logic       above;
    logic       below;
    logic       qualify;
    logic       reached;
    logic       cntInc;
    logic       cntClr;
    logic       alarmNext;
    logic       eventValidNext;
    logic       eventRiseNext;

    assign accept = sample_valid && sample_ready;

    threshold_monitor_cmp8 cmpHi (
        .a      (sample_in),
        .b      (threshold_hi),
        .aGtB_c (above)
    );

    threshold_monitor_cmp8 cmpLo (
        .a      (threshold_lo),
        .b      (sample_in),
        .aGtB_c (below)
    );

    // Qualifying condition depends on which side of the hysteresis we are on
    assign qualify = ((state == ST_NORMAL) || (state == ST_PEND_SET)) ? above : below;
    assign cntInc  = accept && qualify;
    assign cntClr  = accept && (!qualify || reached);

    threshold_monitor_debounce_counter #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) debounce (
        .clk       (clk),
        .rst       (rst),
        .inc       (cntInc),
        .clr       (cntClr),
        .reached_c (reached)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_NORMAL;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: FSM only moves on accepted samples
    always_comb begin
        stateNext = state;
        if (accept) begin
            case (state)
                ST_NORMAL:   if (above) stateNext = reached ? ST_ALARM : ST_PEND_SET;
                ST_PEND_SET: if (!above) stateNext = ST_NORMAL;
                             else if (reached) stateNext = ST_ALARM;
                ST_ALARM:    if (below) stateNext = reached ? ST_NORMAL : ST_PEND_CLR;
                ST_PEND_CLR: if (!below) stateNext = ST_ALARM;
                             else if (reached) stateNext = ST_NORMAL;
                default:     stateNext = ST_NORMAL;
            endcase
        end
    end

    // Output decode: event raised only on genuine alarm set/clear transitions
    always_comb begin
        alarmNext      = alarm;
        eventValidNext = event_valid;
        eventRiseNext  = event_rise;
        if (event_valid && event_ready) begin
            eventValidNext = 1'b0;
        end
        if ((stateNext == ST_ALARM) && ((state == ST_NORMAL) || (state == ST_PEND_SET))) begin
            alarmNext      = 1'b1;
            eventValidNext = 1'b1;
            eventRiseNext  = 1'b1;
        end
        if ((stateNext == ST_NORMAL) && ((state == ST_ALARM) || (state == ST_PEND_CLR))) begin
            alarmNext      = 1'b0;
            eventValidNext = 1'b1;
            eventRiseNext  = 1'b0;
        end
    end

    // Output registers; sample_ready blocks input while the event slot is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm        <= 1'b0;
            event_valid  <= 1'b0;
            event_rise   <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            alarm        <= alarmNext;
            event_valid  <= eventValidNext;
            event_rise   <= eventRiseNext;
            sample_ready <= !eventValidNext;
        end
    end

`ifdef THRESHOLD_MONITOR_PEAK_EN
    // Peak tracking over every accepted sample; ties leave values unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_max <= '0;
            peak_min <= '1;
        end else if (accept) begin
            if (sample_in > peak_max) peak_max <= sample_in;
            if (sample_in < peak_min) peak_min <= sample_in;
        end
    end
`else
    assign peak_max = '0;
    assign peak_min = '1;
`endif

endmodule
